// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding and defaults for the hazard controller
package pipeline_hazard_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam int PEN_W = 3;
  localparam int BRANCH_PENALTY_DEF = 2;
  typedef enum logic [STATE_W-1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    STALL_MEM = 2'd2
  } state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX/WB/mem status in, stall/flush controls and counters out
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 32
);
  logic en;
  logic id_valid;
  logic id_uses_r1;
  logic id_uses_r2;
  logic [REG_ADDR_W-1:0] id_reg_addr_r1;
  logic [REG_ADDR_W-1:0] id_reg_addr_r2;
  logic id_reg_wr;
  logic [REG_ADDR_W-1:0] id_reg_addr_rd;
  logic ex_branch_taken;
  logic wb_reg_wr;
  logic [REG_ADDR_W-1:0] wb_reg_addr;
  logic mem_busy;
  logic stall_fe;
  logic stall_id;
  logic bubble_ex;
  logic flush_fe;
  logic busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output en, id_valid, id_uses_r1, id_uses_r2, id_reg_addr_r1, id_reg_addr_r2,
           id_reg_wr, id_reg_addr_rd, ex_branch_taken, wb_reg_wr, wb_reg_addr, mem_busy,
    input  stall_fe, stall_id, bubble_ex, flush_fe, busy, stall_cnt, flush_cnt
  );
  modport slave (
    input  en, id_valid, id_uses_r1, id_uses_r2, id_reg_addr_r1, id_reg_addr_r2,
           id_reg_wr, id_reg_addr_rd, ex_branch_taken, wb_reg_wr, wb_reg_addr, mem_busy,
    output stall_fe, stall_id, bubble_ex, flush_fe, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// pipeline_hazard_ctrl_reg_scoreboard: pending-write bits with three bypass-aware busy queries
module pipeline_hazard_ctrl_reg_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         set_i,
  input  logic [REG_ADDR_W-1:0]        set_addr_i,
  input  logic                         clr_i,
  input  logic [REG_ADDR_W-1:0]        clr_addr_i,
  input  logic [2:0][REG_ADDR_W-1:0]   q_addr_i,
  output logic [2:0]                   q_busy_o
);
  localparam int NREGS = 2**REG_ADDR_W;
  logic [NREGS-1:0] pending_q, pending_d, set_mask, clr_mask;
  always_comb begin
    set_mask = set_i ? (NREGS'(1) << set_addr_i) : '0;
    clr_mask = clr_i ? (NREGS'(1) << clr_addr_i) : '0;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~NREGS'(1);
  end
  always_ff @(posedge clk)
    if (rst) pending_q <= '0;
    else if (en) pending_q <= pending_d;
  // a same-cycle writeback to the queried register hides its pending bit
  for (genvar i = 0; i < 3; i++) begin : g_q
    assign q_busy_o[i] = pending_q[q_addr_i[i]] && |q_addr_i[i] &&
                         !(WB_BYPASS && clr_i && clr_addr_i == q_addr_i[i]);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: FE/ID stall and flush sequencing from scoreboard, branch and memory status
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int BRANCH_PENALTY = BRANCH_PENALTY_DEF,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  state_e state_q, state_d, eff;
  logic [PEN_W-1:0] pen_q, pen_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [2:0] q_busy;
  logic hz, fire, stall, bubble, flush, br_acc;
  pipeline_hazard_ctrl_reg_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .WB_BYPASS(WB_BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .en(bus.en),
    .set_i(fire),
    .set_addr_i(bus.id_reg_addr_rd),
    .clr_i(bus.wb_reg_wr),
    .clr_addr_i(bus.wb_reg_addr),
    .q_addr_i({bus.id_reg_addr_rd, bus.id_reg_addr_r2, bus.id_reg_addr_r1}),
    .q_busy_o(q_busy)
  );
  // the cycle memory frees up already behaves as RUN
  assign eff = (state_q == STALL_MEM && !bus.mem_busy) ? RUN : state_q;
  assign hz = bus.id_valid && |(q_busy & {bus.id_reg_wr, bus.id_uses_r2, bus.id_uses_r1});
  assign fire = eff == RUN && !bus.mem_busy && !bus.ex_branch_taken && !hz &&
                bus.id_valid && bus.id_reg_wr && |bus.id_reg_addr_rd;
  always_comb begin
    state_d = eff;
    pen_d = pen_q;
    stall = 1'b0;
    bubble = 1'b0;
    flush = 1'b0;
    br_acc = 1'b0;
    if (bus.mem_busy) begin
      stall = 1'b1;
      state_d = STALL_MEM;
      pen_d = '0;
    end else if (eff == FLUSH) begin
      flush = 1'b1;
      bubble = 1'b1;
      pen_d = pen_q - PEN_W'(1);
      state_d = pen_q <= PEN_W'(1) ? RUN : FLUSH;
    end else if (bus.ex_branch_taken) begin
      flush = 1'b1;
      bubble = 1'b1;
      br_acc = 1'b1;
      pen_d = PEN_W'(BRANCH_PENALTY - 1);
      state_d = BRANCH_PENALTY > 1 ? FLUSH : RUN;
    end else if (hz) begin
      stall = 1'b1;
      bubble = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RUN;
      pen_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.en) begin
      state_q <= state_d;
      pen_q <= pen_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
      flush_cnt_q <= flush_cnt_q + CNT_W'(br_acc);
    end
  assign bus.stall_fe = stall && !rst;
  assign bus.stall_id = stall && !rst;
  assign bus.bubble_ex = bubble && !rst;
  assign bus.flush_fe = flush && !rst;
  assign bus.busy = state_q != RUN && !rst;
  assign bus.stall_cnt = rst ? '0 : stall_cnt_q;
  assign bus.flush_cnt = rst ? '0 : flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plan steps then random traffic against a cycle-level reference model
module tb_pipeline_hazard_ctrl;
  localparam int P = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_PENALTY(P), .WB_BYPASS(1'b1), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  logic [31:0] pend_m = '0;
  int flush_left = 0;
  bit memstall = 1'b0;
  logic [31:0] stall_n = '0;
  logic [31:0] flush_n = '0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic bit blk(logic [4:0] a);
    return pend_m[a] && a != 0 && !(bus.wb_reg_wr && bus.wb_reg_addr == a);
  endfunction
  task automatic drive(bit v, bit u1, logic [4:0] r1, bit u2, logic [4:0] r2, bit wr,
                       logic [4:0] rd, bit br, bit wb, logic [4:0] wa, bit mem);
    bus.id_valid = v;
    bus.id_uses_r1 = u1;
    bus.id_reg_addr_r1 = r1;
    bus.id_uses_r2 = u2;
    bus.id_reg_addr_r2 = r2;
    bus.id_reg_wr = wr;
    bus.id_reg_addr_rd = rd;
    bus.ex_branch_taken = br;
    bus.wb_reg_wr = wb;
    bus.wb_reg_addr = wa;
    bus.mem_busy = mem;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // one clock: check outputs for the applied inputs, then advance the model
  task automatic tick(string tag);
    bit hz, st, bub, fl, acc, iss;
    #1;
    hz = bus.id_valid && ((bus.id_uses_r1 && blk(bus.id_reg_addr_r1)) ||
         (bus.id_uses_r2 && blk(bus.id_reg_addr_r2)) || (bus.id_reg_wr && blk(bus.id_reg_addr_rd)));
    {st, bub, fl, acc, iss} = '0;
    if (bus.mem_busy) st = 1;
    else if (flush_left > 0) {fl, bub} = 2'b11;
    else if (bus.ex_branch_taken) {fl, bub, acc} = 3'b111;
    else if (hz) {st, bub} = 2'b11;
    else iss = bus.id_valid && bus.id_reg_wr && bus.id_reg_addr_rd != 0;
    chk({tag, ".stall_fe"}, 32'(bus.stall_fe), 32'(st && !rst));
    chk({tag, ".stall_id"}, 32'(bus.stall_id), 32'(st && !rst));
    chk({tag, ".bubble_ex"}, 32'(bus.bubble_ex), 32'(bub && !rst));
    chk({tag, ".flush_fe"}, 32'(bus.flush_fe), 32'(fl && !rst));
    chk({tag, ".busy"}, 32'(bus.busy), 32'((flush_left > 0 || memstall) && !rst));
    chk({tag, ".stall_cnt"}, bus.stall_cnt, rst ? 32'd0 : stall_n);
    chk({tag, ".flush_cnt"}, bus.flush_cnt, rst ? 32'd0 : flush_n);
    if (!rst) chk({tag, ".pending"}, dut.u_sb.pending_q, pend_m);
    @(posedge clk);
    if (rst) begin
      pend_m = '0;
      flush_left = 0;
      memstall = 0;
      stall_n = '0;
      flush_n = '0;
    end else if (bus.en) begin
      if (bus.wb_reg_wr) pend_m[bus.wb_reg_addr] = 1'b0;
      if (iss) pend_m[bus.id_reg_addr_rd] = 1'b1;
      stall_n += 32'(st);
      flush_n += 32'(acc);
      flush_left = bus.mem_busy ? 0 : flush_left > 0 ? flush_left - 1 : acc ? P - 1 : 0;
      memstall = bus.mem_busy;
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    idle();
    @(negedge clk);
    tick("reset");
    rst = 1'b0;
    tick("post_reset");
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    tick("issue_x5");
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick("raw_x5");
    drive(1, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0);
    tick("raw_x5_bypass");
    idle();
    tick("after_wb5");
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick("write_x0");
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("read_x0");
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
    tick("branch");
    idle();
    tick("flush2");
    tick("after_flush");
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tick("issue_x3");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick("branch_b");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
    tick("mem_wb3");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick("mem_hold");
    idle();
    tick("mem_release");
    tick("mem_after");
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    tick("issue_x7");
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    tick("waw_x7");
    drive(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0);
    tick("waw_set_wins");
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("raw_x7");
    rst = 1'b1;
    tick("mid_rst");
    rst = 1'b0;
    idle();
    tick("after_mid_rst");
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    tick("issue_x4");
    bus.en = 1'b0;
    drive(1, 1, 4, 0, 0, 1, 6, 0, 1, 4, 0);
    repeat (4) tick("en_off");
    bus.en = 1'b1;
    tick("en_on");
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(63) == 0);
      bus.en = ($urandom_range(7) != 0);
      drive($urandom_range(3) != 0, $urandom_range(1), 5'($urandom_range(7)), $urandom_range(1),
            5'($urandom_range(7)), $urandom_range(1), 5'($urandom_range(7)), $urandom_range(9) == 0,
            $urandom_range(2) == 0, 5'($urandom_range(7)), $urandom_range(5) == 0);
      tick("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
